// File: rtl/intersection_phase_scheduler_pkg.sv
// traffic_pkg
// Shared definitions for the intersection scheduler, the lamp controller and
// the testbench: state codes, direction codes and default phase durations.
// No ports; this file only holds constants.
package traffic_pkg;

    // State codes, also visible on STATE_O for debug
    localparam logic [2:0] ST_FLASH = 3'd0;
    localparam logic [2:0] ST_AR_A  = 3'd1;
    localparam logic [2:0] ST_NS_G  = 3'd2;
    localparam logic [2:0] ST_NS_Y  = 3'd3;
    localparam logic [2:0] ST_AR_B  = 3'd4;
    localparam logic [2:0] ST_EW_G  = 3'd5;
    localparam logic [2:0] ST_EW_Y  = 3'd6;
    localparam logic [2:0] ST_WALK  = 3'd7;

    // Direction codes: which green follows a WALK phase
    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    // Default durations, counted in TICK_I strobes
    localparam int DEF_GREEN_TICKS   = 30;
    localparam int DEF_YELLOW_TICKS  = 3;
    localparam int DEF_ALL_RED_TICKS = 2;
    localparam int DEF_WALK_TICKS    = 10;
    localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/intersection_phase_scheduler_timer.sv
// phase_timer
// Loadable down-counter that measures how many ticks remain in a phase.
// Ports:
//   CLK_I, RST_I : clock, asynchronous active-high reset
//   LOAD         : load LOAD_VAL (remaining ticks minus one)
//   LOAD_VAL     : value loaded on phase entry
//   TICK         : timing strobe; decrements a non-zero count
//   CLR          : force the count to zero (highest priority)
//   DONE         : last tick of the phase is happening this cycle
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             LOAD,
    input  logic [CNT_W-1:0] LOAD_VAL,
    input  logic             TICK,
    input  logic             CLR,
    output logic             DONE
);

    logic [CNT_W-1:0] r_cnt;

    // Clear beats load, load beats decrement; the count holds at zero until
    // the owner reloads it.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_cnt <= '0;
        end else if (CLR) begin
            r_cnt <= '0;
        end else if (LOAD) begin
            r_cnt <= LOAD_VAL;
        end else if (TICK && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign DONE = (r_cnt == '0) & TICK;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler
// Sequences a two-way intersection with an all-red clearance between greens
// and an optional shared pedestrian WALK phase; EN_I low gives flashing yellow.
// Ports:
//   CLK_I, RST_I            : clock, asynchronous active-high reset
//   EN_I                    : 1 = normal sequencing, 0 = flashing yellow
//   TICK_I                  : timing strobe from an external prescaler
//   PED_REQ_I               : pedestrian button (level or pulse)
//   NS_*_O, EW_*_O, WALK_O  : registered lamp outputs
//   PED_PEND_O              : pedestrian request latched, not yet served
//   STATE_O                 : current state code
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS   = DEF_GREEN_TICKS,
    parameter int YELLOW_TICKS  = DEF_YELLOW_TICKS,
    parameter int ALL_RED_TICKS = DEF_ALL_RED_TICKS,
    parameter int WALK_TICKS    = DEF_WALK_TICKS,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       EN_I,
    input  logic       TICK_I,
    input  logic       PED_REQ_I,
    output logic       NS_RED_O,
    output logic       NS_YELLOW_O,
    output logic       NS_GREEN_O,
    output logic       EW_RED_O,
    output logic       EW_YELLOW_O,
    output logic       EW_GREEN_O,
    output logic       WALK_O,
    output logic       PED_PEND_O,
    output logic [2:0] STATE_O
);

    localparam logic [CNT_W-1:0] LD_GREEN   = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW  = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] LD_ALL_RED = CNT_W'(ALL_RED_TICKS - 1);
    localparam logic [CNT_W-1:0] LD_WALK    = CNT_W'(WALK_TICKS - 1);

    logic [2:0]       r_state;
    logic             r_dir;
    logic             r_flash;
    logic             r_ped_pend;
    logic [6:0]       r_lamps;

    logic [2:0]       w_next_state;
    logic             w_next_dir;
    logic             w_next_flash;
    logic             w_next_pend;
    logic [6:0]       w_next_lamps;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_clr;
    logic             w_done;

    function automatic logic [CNT_W-1:0] loadFor(input logic [2:0] s);
        case (s)
            ST_NS_G, ST_EW_G: loadFor = LD_GREEN;
            ST_NS_Y, ST_EW_Y: loadFor = LD_YELLOW;
            ST_WALK:          loadFor = LD_WALK;
            default:          loadFor = LD_ALL_RED;
        endcase
    endfunction

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .LOAD     (w_load),
        .LOAD_VAL (w_load_val),
        .TICK     (TICK_I),
        .CLR      (w_clr),
        .DONE     (w_done)
    );

    // Next-state logic. Disable wins over everything, FLASH exit ignores the
    // tick on that cycle (the timer is freshly loaded), otherwise the phase
    // only moves when the timer reports its final tick.
    always_comb begin
        w_next_state = r_state;
        w_next_dir   = r_dir;
        w_load       = 1'b0;
        w_clr        = 1'b0;
        if (!EN_I) begin
            w_next_state = ST_FLASH;
            w_clr        = 1'b1;
        end else if (r_state == ST_FLASH) begin
            w_next_state = ST_AR_A;
            w_next_dir   = DIR_NS;
            w_load       = 1'b1;
        end else if (w_done) begin
            w_load = 1'b1;
            case (r_state)
                ST_AR_A: begin
                    w_next_state = r_ped_pend ? ST_WALK : ST_NS_G;
                    w_next_dir   = DIR_NS;
                end
                ST_NS_G: w_next_state = ST_NS_Y;
                ST_NS_Y: w_next_state = ST_AR_B;
                ST_AR_B: begin
                    w_next_state = r_ped_pend ? ST_WALK : ST_EW_G;
                    w_next_dir   = DIR_EW;
                end
                ST_EW_G: w_next_state = ST_EW_Y;
                ST_EW_Y: w_next_state = ST_AR_A;
                ST_WALK: w_next_state = (r_dir == DIR_NS) ? ST_NS_G : ST_EW_G;
                default: w_next_state = ST_FLASH;
            endcase
        end
        w_load_val = loadFor(w_next_state);
    end

    // Flash phase bit and pedestrian latch. Entering WALK clears the latch
    // even if the button is pressed on that same cycle.
    always_comb begin
        w_next_flash = 1'b0;
        if (w_next_state == ST_FLASH) begin
            w_next_flash = (r_state == ST_FLASH && TICK_I) ? ~r_flash : r_flash;
        end
        w_next_pend = r_ped_pend;
        if (!EN_I) begin
            w_next_pend = 1'b0;
        end else if (w_next_state == ST_WALK && r_state != ST_WALK) begin
            w_next_pend = 1'b0;
        end else if (PED_REQ_I && r_state != ST_WALK && r_state != ST_FLASH) begin
            w_next_pend = 1'b1;
        end
    end

    // Lamps decoded from the next state so the registered outputs change on
    // the same edge as the state. Order: NS R,Y,G, EW R,Y,G, WALK.
    always_comb begin
        w_next_lamps = 7'b0;
        case (w_next_state)
            ST_FLASH:         w_next_lamps = {1'b0, w_next_flash, 1'b0, 1'b0, w_next_flash, 1'b0, 1'b0};
            ST_AR_A, ST_AR_B: w_next_lamps = 7'b100_100_0;
            ST_WALK:          w_next_lamps = 7'b100_100_1;
            ST_NS_G:          w_next_lamps = 7'b001_100_0;
            ST_NS_Y:          w_next_lamps = 7'b010_100_0;
            ST_EW_G:          w_next_lamps = 7'b100_001_0;
            ST_EW_Y:          w_next_lamps = 7'b100_010_0;
            default:          w_next_lamps = 7'b0;
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state    <= ST_FLASH;
            r_dir      <= DIR_NS;
            r_flash    <= 1'b0;
            r_ped_pend <= 1'b0;
            r_lamps    <= 7'b0;
        end else begin
            r_state    <= w_next_state;
            r_dir      <= w_next_dir;
            r_flash    <= w_next_flash;
            r_ped_pend <= w_next_pend;
            r_lamps    <= w_next_lamps;
        end
    end

    assign {NS_RED_O, NS_YELLOW_O, NS_GREEN_O,
            EW_RED_O, EW_YELLOW_O, EW_GREEN_O, WALK_O} = r_lamps;
    assign PED_PEND_O = r_ped_pend;
    assign STATE_O    = r_state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb_intersection_phase_scheduler
// Scoreboard bench: a behavioural model predicts the outputs after every
// edge, pushes them to a queue, and each scenario task pops and compares.
module tb_intersection_phase_scheduler;
    import traffic_pkg::*;

    localparam int G  = 4;
    localparam int Y  = 2;
    localparam int AR = 1;
    localparam int W  = 3;

    logic       CLK_I = 1'b0;
    logic       RST_I, EN_I, TICK_I, PED_REQ_I;
    logic       NS_RED_O, NS_YELLOW_O, NS_GREEN_O;
    logic       EW_RED_O, EW_YELLOW_O, EW_GREEN_O;
    logic       WALK_O, PED_PEND_O;
    logic [2:0] STATE_O;

    int checks   = 0;
    int failures = 0;

    logic [10:0] expQ[$];
    logic [10:0] expV;

    logic [2:0] mState;
    int         mElapsed;
    logic       mDir, mFlash, mPend;

    intersection_phase_scheduler #(
        .GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALL_RED_TICKS(AR),
        .WALK_TICKS(W), .CNT_W(8)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .EN_I(EN_I), .TICK_I(TICK_I),
        .PED_REQ_I(PED_REQ_I),
        .NS_RED_O(NS_RED_O), .NS_YELLOW_O(NS_YELLOW_O), .NS_GREEN_O(NS_GREEN_O),
        .EW_RED_O(EW_RED_O), .EW_YELLOW_O(EW_YELLOW_O), .EW_GREEN_O(EW_GREEN_O),
        .WALK_O(WALK_O), .PED_PEND_O(PED_PEND_O), .STATE_O(STATE_O)
    );

    always #5 CLK_I = ~CLK_I;

    function automatic int durOf(input logic [2:0] s);
        case (s)
            ST_NS_G, ST_EW_G: return G;
            ST_NS_Y, ST_EW_Y: return Y;
            ST_WALK:          return W;
            default:          return AR;
        endcase
    endfunction

    // Expected {state, NS R/Y/G, EW R/Y/G, walk, pend} for a model state
    function automatic logic [10:0] expVec(input logic [2:0] s, input logic fl, input logic pd);
        logic nr, ny, ng, er, ey, eg, wk;
        {nr, ny, ng, er, ey, eg, wk} = 7'b0;
        case (s)
            ST_FLASH: begin ny = fl; ey = fl; end
            ST_AR_A, ST_AR_B: begin nr = 1'b1; er = 1'b1; end
            ST_WALK: begin nr = 1'b1; er = 1'b1; wk = 1'b1; end
            ST_NS_G: begin ng = 1'b1; er = 1'b1; end
            ST_NS_Y: begin ny = 1'b1; er = 1'b1; end
            ST_EW_G: begin nr = 1'b1; eg = 1'b1; end
            default: begin nr = 1'b1; ey = 1'b1; end
        endcase
        return {s, nr, ny, ng, er, ey, eg, wk, pd};
    endfunction

    function automatic logic [10:0] obsVec();
        return {STATE_O, NS_RED_O, NS_YELLOW_O, NS_GREEN_O,
                EW_RED_O, EW_YELLOW_O, EW_GREEN_O, WALK_O, PED_PEND_O};
    endfunction

    task automatic modelReset();
        mState = ST_FLASH; mElapsed = 0; mDir = DIR_NS; mFlash = 1'b0; mPend = 1'b0;
        expQ.delete();
    endtask

    // Drive one cycle of inputs and push what the outputs must be after the edge
    task automatic cycle(input logic en, input logic tick, input logic ped);
        logic [2:0] s;
        logic [2:0] nxt;
        logic       newPend;
        EN_I = en; TICK_I = tick; PED_REQ_I = ped;
        s = mState;
        if (!en) begin
            mFlash   = (s == ST_FLASH) ? (tick ? ~mFlash : mFlash) : 1'b0;
            mState   = ST_FLASH;
            mElapsed = 0;
            mPend    = 1'b0;
        end else if (s == ST_FLASH) begin
            mState = ST_AR_A; mElapsed = 0; mDir = DIR_NS; mFlash = 1'b0;
        end else begin
            nxt = s;
            if (tick) begin
                if (mElapsed + 1 == durOf(s)) begin
                    mElapsed = 0;
                    case (s)
                        ST_AR_A: begin mDir = DIR_NS; nxt = mPend ? ST_WALK : ST_NS_G; end
                        ST_NS_G: nxt = ST_NS_Y;
                        ST_NS_Y: nxt = ST_AR_B;
                        ST_AR_B: begin mDir = DIR_EW; nxt = mPend ? ST_WALK : ST_EW_G; end
                        ST_EW_G: nxt = ST_EW_Y;
                        ST_EW_Y: nxt = ST_AR_A;
                        default: nxt = (mDir == DIR_NS) ? ST_NS_G : ST_EW_G;
                    endcase
                end else begin
                    mElapsed++;
                end
            end
            newPend = mPend;
            if (ped && s != ST_WALK) newPend = 1'b1;
            if (nxt == ST_WALK && s != ST_WALK) newPend = 1'b0;
            mPend  = newPend;
            mState = nxt;
        end
        expQ.push_back(expVec(mState, mFlash, mPend));
    endtask

    // Invariants on every settled cycle outside reset and FLASH
    always @(negedge CLK_I) begin
        if (!RST_I && STATE_O != ST_FLASH) begin
            checks++;
            if (((NS_GREEN_O | NS_YELLOW_O) & (EW_GREEN_O | EW_YELLOW_O)) !== 1'b0) begin
                failures++;
                $display("[TB] FAIL inv_conflict t=%0t: state %0d both heads moving", $time, STATE_O);
            end
            checks++;
            if (WALK_O && !(NS_RED_O && EW_RED_O)) begin
                failures++;
                $display("[TB] FAIL inv_walk_reds t=%0t: reds %b%b, required 11", $time, NS_RED_O, EW_RED_O);
            end
            checks++;
            if (!$onehot({NS_RED_O, NS_YELLOW_O, NS_GREEN_O}) || !$onehot({EW_RED_O, EW_YELLOW_O, EW_GREEN_O})) begin
                failures++;
                $display("[TB] FAIL inv_onehot t=%0t: NS %b%b%b EW %b%b%b", $time,
                         NS_RED_O, NS_YELLOW_O, NS_GREEN_O, EW_RED_O, EW_YELLOW_O, EW_GREEN_O);
            end
        end
    end

    // Reset at start, flashing yellows, then a mid-cycle asynchronous reset
    task automatic test_reset();
        logic yellowSeq[4];
        yellowSeq = '{1'b1, 1'b0, 1'b1, 1'b0};
        RST_I = 1'b1; EN_I = 1'b0; TICK_I = 1'b1; PED_REQ_I = 1'b0;
        #12;
        checks++;
        if (obsVec() !== 11'b0) begin
            failures++;
            $display("[TB] FAIL reset_hold: got %b required %b", obsVec(), 11'b0);
        end
        RST_I = 1'b0;
        modelReset();
        for (int i = 0; i < 7; i++) begin
            cycle(i >= 4, 1'b1, 1'b0);
            @(posedge CLK_I); #1;
            expV = expQ.pop_front();
            checks++;
            if (obsVec() !== expV) begin
                failures++;
                $display("[TB] FAIL reset_seq cyc %0d: got %b required %b", i, obsVec(), expV);
            end
            if (i < 4) begin
                checks++;
                if (NS_YELLOW_O !== yellowSeq[i] || EW_YELLOW_O !== yellowSeq[i]) begin
                    failures++;
                    $display("[TB] FAIL flash_yellow cyc %0d: got %b%b required %b", i,
                             NS_YELLOW_O, EW_YELLOW_O, yellowSeq[i]);
                end
            end
        end
        #3;
        EN_I = 1'b0; RST_I = 1'b1;
        #1;
        checks++;
        if (obsVec() !== 11'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: got %b required %b", obsVec(), 11'b0);
        end
        #2;
        RST_I = 1'b0;
        modelReset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            @(posedge CLK_I); #1;
            expV = expQ.pop_front();
            checks++;
            if (obsVec() !== expV) begin
                failures++;
                $display("[TB] FAIL reset_flash cyc %0d: got %b required %b", i, obsVec(), expV);
            end
        end
    endtask

    // One full period from FLASH exit with no pedestrians
    task automatic test_full_cycle();
        logic [2:0] stateSeq[15];
        stateSeq = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4,
                     3'd5, 3'd5, 3'd5, 3'd5, 3'd6, 3'd6, 3'd1};
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            @(posedge CLK_I); #1;
            expV = expQ.pop_front();
            checks++;
            if (obsVec() !== expV) begin
                failures++;
                $display("[TB] FAIL full_cycle cyc %0d: got %b required %b", i, obsVec(), expV);
            end
            checks++;
            if (STATE_O !== stateSeq[i]) begin
                failures++;
                $display("[TB] FAIL full_cycle_state cyc %0d: got %0d required %0d", i, STATE_O, stateSeq[i]);
            end
        end
    endtask

    // Request pulsed in NS green is served after AR_B for exactly WALK ticks
    task automatic test_ped_request();
        int walkCycles = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, i == 2);
            @(posedge CLK_I); #1;
            expV = expQ.pop_front();
            checks++;
            if (obsVec() !== expV) begin
                failures++;
                $display("[TB] FAIL ped_request cyc %0d: got %b required %b", i, obsVec(), expV);
            end
            if (WALK_O) walkCycles++;
        end
        checks++;
        if (walkCycles !== W) begin
            failures++;
            $display("[TB] FAIL ped_walk_len: got %0d cycles required %0d", walkCycles, W);
        end
    endtask

    // Button held through WALK (and on its entry cycle) must not re-latch
    task automatic test_walk_hold();
        int walkEntries = 0;
        logic [2:0] prevState;
        logic ped;
        prevState = STATE_O;
        for (int i = 0; i < 40; i++) begin
            ped = (i == 0) || (mState == ST_WALK) ||
                  (mPend && (mState == ST_AR_A || mState == ST_AR_B));
            cycle(1'b1, 1'b1, ped);
            @(posedge CLK_I); #1;
            expV = expQ.pop_front();
            checks++;
            if (obsVec() !== expV) begin
                failures++;
                $display("[TB] FAIL walk_hold cyc %0d: got %b required %b", i, obsVec(), expV);
            end
            if (STATE_O == ST_WALK && prevState != ST_WALK) walkEntries++;
            prevState = STATE_O;
        end
        checks++;
        if (walkEntries !== 1) begin
            failures++;
            $display("[TB] FAIL walk_hold_entries: got %0d required 1", walkEntries);
        end
    endtask

    // Drop EN_I in EW green, flash, then re-enable into AR_A and NS green
    task automatic test_disable_mid_green();
        int guard = 0;
        while (mState != ST_EW_G && guard < 30) begin
            cycle(1'b1, 1'b1, 1'b0);
            @(posedge CLK_I); #1;
            expV = expQ.pop_front();
            checks++;
            if (obsVec() !== expV) begin
                failures++;
                $display("[TB] FAIL disable_lead cyc %0d: got %b required %b", guard, obsVec(), expV);
            end
            guard++;
        end
        checks++;
        if (mState != ST_EW_G) begin
            failures++;
            $display("[TB] FAIL disable_reach_ewg: got state %0d required %0d", STATE_O, ST_EW_G);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(i == 0 || i == 4 || i == 5, 1'b1, 1'b0);
            @(posedge CLK_I); #1;
            expV = expQ.pop_front();
            checks++;
            if (obsVec() !== expV) begin
                failures++;
                $display("[TB] FAIL disable_seq cyc %0d: got %b required %b", i, obsVec(), expV);
            end
            if (i == 1) begin
                checks++;
                if (STATE_O !== ST_FLASH || EW_GREEN_O !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL disable_flash: got state %0d green %b required 0 0", STATE_O, EW_GREEN_O);
                end
            end
            if (i == 4) begin
                checks++;
                if (STATE_O !== ST_AR_A || !(NS_RED_O && EW_RED_O)) begin
                    failures++;
                    $display("[TB] FAIL reenable_ar: got state %0d reds %b%b required 1 11",
                             STATE_O, NS_RED_O, EW_RED_O);
                end
            end
            if (i == 5) begin
                checks++;
                if (STATE_O !== ST_NS_G) begin
                    failures++;
                    $display("[TB] FAIL reenable_nsg: got state %0d required %0d", STATE_O, ST_NS_G);
                end
            end
        end
    endtask

    // Ticks every 4th cycle: a fresh NS green lasts 4*G cycles
    task automatic test_sparse_ticks();
        int  runLen  = 0;
        bit  sawOther = 0;
        bit  done    = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            cycle(1'b1, (i % 4) == 0, 1'b0);
            @(posedge CLK_I); #1;
            expV = expQ.pop_front();
            checks++;
            if (obsVec() !== expV) begin
                failures++;
                $display("[TB] FAIL sparse cyc %0d: got %b required %b", i, obsVec(), expV);
            end
            if (STATE_O != ST_NS_G) begin
                if (runLen > 0) done = 1;
                sawOther = 1;
            end else if (sawOther) begin
                runLen++;
            end
        end
        checks++;
        if (!done || runLen !== 4 * G) begin
            failures++;
            $display("[TB] FAIL sparse_ns_green_len: got %0d cycles required %0d", runLen, 4 * G);
        end
    endtask

    // Random enable, tick and button traffic against the model
    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 19) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0);
            @(posedge CLK_I); #1;
            expV = expQ.pop_front();
            checks++;
            if (obsVec() !== expV) begin
                failures++;
                $display("[TB] FAIL random cyc %0d: got %b required %b", i, obsVec(), expV);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_ped_request();
        test_walk_hold();
        test_disable_mid_green();
        test_sparse_ticks();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
